// File: rtl/bsg_link_pkg.sv
// Shared link constants so upstream and downstream agree on credit math.
// Pure definitions; no logic, no latency, no backpressure.
package bsg_link_pkg;
    localparam int bsg_link_credits_lp              = 64;
    localparam int bsg_link_lg_credits_lp           = $clog2(bsg_link_credits_lp);
    localparam int bsg_link_lg_credit_decimation_lp = 3;
    localparam int bsg_link_word_width_lp           = 32;

    typedef logic [31:0] bsg_link_word_t;
endpackage

// File: rtl/bsg_link_downstream_token_return_if.sv
// Bundle of the io-side write, core-side valid/ready read and credit/debug outputs.
// slave = the downstream block; master = whatever drives io words and consumes core words.
interface bsg_link_downstream_token_return_if
    import bsg_link_pkg::*;
#(
    parameter int WIDTH         = bsg_link_word_width_lp,
    parameter int LG_FIFO_DEPTH = bsg_link_lg_credits_lp
);
    logic                     io_valid_i;
    logic [WIDTH-1:0]         io_data_i;
    logic                     core_valid_o;
    logic [WIDTH-1:0]         core_data_o;
    logic                     core_ready_i;
    logic                     token_o;
    logic [LG_FIFO_DEPTH:0]   deq_count_o;
    logic                     overflow_o;

    modport master (
        output io_valid_i, io_data_i, core_ready_i,
        input  core_valid_o, core_data_o, token_o, deq_count_o, overflow_o
    );

    modport slave (
        input  io_valid_i, io_data_i, core_ready_i,
        output core_valid_o, core_data_o, token_o, deq_count_o, overflow_o
    );
endinterface

// File: rtl/bsg_link_credit_fifo.sv
// Credit-sized FIFO: unconditional write port, valid/ready read port, sticky overflow.
// 1-cycle write-to-read latency; writes into a full FIFO without a same-cycle read are dropped.
module bsg_link_credit_fifo
    import bsg_link_pkg::*;
#(
    parameter int WIDTH    = $bits(bsg_link_word_t),
    parameter int LG_DEPTH = bsg_link_lg_credits_lp
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_v_i,
    input  logic [WIDTH-1:0] w_data_i,
    output logic             r_v_o,
    output logic [WIDTH-1:0] r_data_o,
    input  logic             r_ready_i,
    output logic             deq_o,
    output logic             overflow_o
);
    localparam int              DEPTH   = 1 << LG_DEPTH;
    localparam logic [LG_DEPTH:0] PTR_ONE = 1;

    logic [LG_DEPTH:0] wptr_q, wptr_d;
    logic [LG_DEPTH:0] rptr_q, rptr_d;
    logic              overflow_q, overflow_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic empty;
    logic full;
    logic wr;

    assign empty = (wptr_q == rptr_q);
    // One extra pointer bit separates full from empty when the low bits match.
    assign full  = (wptr_q[LG_DEPTH] != rptr_q[LG_DEPTH]) &&
                   (wptr_q[LG_DEPTH-1:0] == rptr_q[LG_DEPTH-1:0]);

    assign deq_o = !empty && r_ready_i;
    assign wr    = w_v_i && (!full || deq_o);

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        overflow_d = overflow_q;
        if (wr) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (deq_o) begin
            rptr_d = rptr_q + PTR_ONE;
        end
        if (w_v_i && !wr) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            overflow_q <= overflow_d;
        end
    end

    // A write into a full FIFO alongside a read lands in the slot being vacated.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wptr_q[LG_DEPTH-1:0]] <= w_data_i;
        end
    end

    assign r_v_o      = !empty;
    assign r_data_o   = empty ? '0 : mem_q[rptr_q[LG_DEPTH-1:0]];
    assign overflow_o = overflow_q;
endmodule

// File: rtl/bsg_link_downstream_token_return.sv
// Receive side of the DDR link: buffers io words, hands them to core, toggles a credit token.
// 1-cycle io-to-core latency; core backpressure via core_ready_i, io side has none (credit-protected).
module bsg_link_downstream_token_return
    import bsg_link_pkg::*;
#(
    parameter int WIDTH                = bsg_link_word_width_lp,
    parameter int LG_FIFO_DEPTH        = bsg_link_lg_credits_lp,
    parameter int LG_CREDIT_DECIMATION = bsg_link_lg_credit_decimation_lp
) (
    input  logic                                     clk,
    input  logic                                     rst,
    bsg_link_downstream_token_return_if.slave        link
);
    localparam logic [LG_CREDIT_DECIMATION-1:0] DEC_ONE = 1;
    localparam logic [LG_FIFO_DEPTH:0]          CNT_ONE = 1;

    logic                            deq;
    logic [LG_CREDIT_DECIMATION-1:0] dec_q, dec_d;
    logic                            token_q, token_d;
    logic [LG_FIFO_DEPTH:0]          deq_count_q, deq_count_d;

    bsg_link_credit_fifo #(
        .WIDTH    (WIDTH),
        .LG_DEPTH (LG_FIFO_DEPTH)
    ) fifo (
        .clk        (clk),
        .rst        (rst),
        .w_v_i      (link.io_valid_i),
        .w_data_i   (link.io_data_i),
        .r_v_o      (link.core_valid_o),
        .r_data_o   (link.core_data_o),
        .r_ready_i  (link.core_ready_i),
        .deq_o      (deq),
        .overflow_o (link.overflow_o)
    );

    // Token flips when the decimation counter wraps; partial credits are held, never flushed.
    always_comb begin
        dec_d       = dec_q;
        token_d     = token_q;
        deq_count_d = deq_count_q;
        if (deq) begin
            dec_d       = dec_q + DEC_ONE;
            deq_count_d = deq_count_q + CNT_ONE;
            if (dec_q == '1) begin
                token_d = ~token_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_q       <= '0;
            token_q     <= 1'b0;
            deq_count_q <= '0;
        end else begin
            dec_q       <= dec_d;
            token_q     <= token_d;
            deq_count_q <= deq_count_d;
        end
    end

    assign link.token_o     = token_q;
    assign link.deq_count_o = deq_count_q;
endmodule

// File: tb/tb_bsg_link_downstream_token_return.sv
// Scoreboard bench for the downstream token-return block: directed scenarios plus random traffic.
// Reference model tracks occupancy, total dequeues since reset and sticky overflow.
module tb_bsg_link_downstream_token_return;
    import bsg_link_pkg::*;

    localparam int DEPTH = 64;
    localparam int LCD   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bsg_link_downstream_token_return_if #(.WIDTH(32), .LG_FIFO_DEPTH(6)) link_if ();

    bsg_link_downstream_token_return #(
        .WIDTH                (32),
        .LG_FIFO_DEPTH        (6),
        .LG_CREDIT_DECIMATION (LCD)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .link (link_if)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;

    // Reference model state
    bsg_link_word_t exp_q[$];
    int             m_cnt       = 0;
    int             m_deq_total = 0;
    bit             m_ovf       = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each clock edge from the inputs the bench applied.
    always @(posedge clk) begin
        bit deq;
        if (rst) begin
            m_cnt       = 0;
            m_deq_total = 0;
            m_ovf       = 1'b0;
            exp_q.delete();
        end else begin
            deq = link_if.core_ready_i && (m_cnt > 0);
            if (link_if.io_valid_i) begin
                if (m_cnt < DEPTH || deq) begin
                    exp_q.push_back(link_if.io_data_i);
                    m_cnt++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (deq) begin
                m_cnt--;
                m_deq_total++;
            end
        end
    end

    // Monitor: compare outputs against the model mid-cycle, pop data on handshakes.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("core_valid", 64'(link_if.core_valid_o), 64'(m_cnt != 0));
            chk("token", 64'(link_if.token_o), 64'((m_deq_total >> LCD) & 1));
            chk("deq_count", 64'(link_if.deq_count_o), 64'(m_deq_total % (2 * DEPTH)));
            chk("overflow", 64'(link_if.overflow_o), 64'(m_ovf));
            if (link_if.core_valid_o && link_if.core_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL core_data: got 0x%0h, expected no word at %0t",
                             link_if.core_data_o, $time);
                end else begin
                    chk("core_data", 64'(link_if.core_data_o), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] d, input logic r);
        link_if.io_valid_i   = v;
        link_if.io_data_i    = d;
        link_if.core_ready_i = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 32'h0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        link_if.io_valid_i   = 1'b0;
        link_if.io_data_i    = '0;
        link_if.core_ready_i = 1'b0;

        // 1: reset then idle
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        rst    = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("t1_valid", 64'(link_if.core_valid_o), 64'h0);
        chk("t1_token", 64'(link_if.token_o), 64'h0);

        // 2: eight streamed words
        for (int i = 1; i <= 8; i++) step(1'b1, 32'hDEAD_0000 + 32'(i), 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("t2_deq_count", 64'(link_if.deq_count_o), 64'd8);
        chk("t2_token", 64'(link_if.token_o), 64'd1);

        // 3: fill, overflow, drain
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'hA000_0000 + 32'(i), 1'b0);
        @(negedge clk);
        chk("t3_ovf_before", 64'(link_if.overflow_o), 64'd0);
        step(1'b1, 32'hBAD0_0065, 1'b0);
        @(negedge clk);
        chk("t3_ovf_after", 64'(link_if.overflow_o), 64'd1);
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("t3_deq_count", 64'(link_if.deq_count_o), 64'd72);
        chk("t3_token", 64'(link_if.token_o), 64'd1);
        chk("t3_ovf_sticky", 64'(link_if.overflow_o), 64'd1);

        // 4: write into full FIFO with a same-cycle dequeue
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'hC000_0000 + 32'(i), 1'b0);
        step(1'b1, 32'hC000_0040, 1'b1);
        @(negedge clk);
        chk("t4_ovf", 64'(link_if.overflow_o), 64'd0);
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("t4_deq_count", 64'(link_if.deq_count_o), 64'd65);

        // 5: 130 dequeues wrap the debug counter
        do_reset();
        for (int i = 0; i < 130; i++) step(1'b1, $urandom, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("t5_deq_count", 64'(link_if.deq_count_o), 64'd2);
        chk("t5_token", 64'(link_if.token_o), 64'd0);
        chk("t5_dec_ctr", 64'(link_if.deq_count_o[LCD-1:0]), 64'd2);

        // 6: reset mid-operation
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 32'hE000_0000 + 32'(i), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);
        rst = 1'b1;
        step(1'b0, 32'h0, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_valid", 64'(link_if.core_valid_o), 64'd0);
        chk("t6_token", 64'(link_if.token_o), 64'd0);
        chk("t6_deq_count", 64'(link_if.deq_count_o), 64'd0);
        for (int i = 0; i < 7; i++) step(1'b1, 32'hF000_0000 + 32'(i), 1'b1);
        step(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("t6_token_7", 64'(link_if.token_o), 64'd0);
        step(1'b1, 32'hF000_0007, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("t6_token_8", 64'(link_if.token_o), 64'd1);

        // 7: random traffic with varying core backpressure and rare resets
        do_reset();
        for (int seg = 0; seg < 15; seg++) begin
            int pr;
            case ($urandom_range(0, 2))
                0:       pr = 10;
                1:       pr = 50;
                default: pr = 95;
            endcase
            for (int i = 0; i < 200; i++) begin
                rst = ($urandom_range(0, 599) == 0);
                step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 99) < pr);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < DEPTH + 6; i++) step(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("t7_drained", 64'(link_if.core_valid_o), 64'd0);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
